// File: rtl/test_bcd_to_7_seg.sv
// Push-button BCD counter (0..9) driving one common-anode 7-segment display.
// Define BCD_7SEG_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES-long debounce filter after the synchronizer.
module test_bcd_to_7_seg #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       enable,
  input  logic       seg7all_on,
  output logic [6:0] sg7
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
    return (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
  endfunction

  logic       r_sync_p0;
  logic       r_sync_p1;
  logic       w_filt;
  logic       r_filt_prev;
  logic [1:0] r_warm;
  logic       r_armed;
  logic       w_press;
  logic [3:0] r_digit;
  logic [6:0] r_sg7;

  // Stage p0/p1: two-flop synchronizer, idles at the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= button;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef BCD_7SEG_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_db_cnt;
  logic             r_filt;

  // Debounce: the synchronized level must disagree for DEBOUNCE_CYCLES edges in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b1;
    end else if (r_sync_p1 == r_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == CNT_LAST) begin
      r_db_cnt <= '0;
      r_filt   <= r_sync_p1;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync_p1;
`endif

  // A button held through reset must be seen released before its falling edge can count
  assign w_press = r_armed & r_filt_prev & ~w_filt;

  // Counter stage: falling-edge detect and BCD increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_prev <= 1'b1;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
      r_digit     <= 4'd0;
    end else begin
      r_filt_prev <= w_filt;
      r_warm      <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_sync_p1 && w_filt)
        r_armed <= 1'b1;
      if (w_press && enable)
        r_digit <= bcd_inc(r_digit);
    end
  end

  // Output stage: blank beats lamp test beats decoded digit
  always_ff @(posedge clk) begin
    if (rst)
      r_sg7 <= SEG_BLANK;
    else if (!enable)
      r_sg7 <= SEG_BLANK;
    else if (seg7all_on)
      r_sg7 <= SEG_ALL;
    else
      r_sg7 <= seg_decode(r_digit);
  end

  assign sg7 = r_sg7;

endmodule

// File: tb/tb_test_bcd_to_7_seg.sv
// Scoreboard bench for test_bcd_to_7_seg: stimulus queues expected sg7 values with a due cycle,
// a monitor compares them on the falling edge of that cycle.
module tb_test_bcd_to_7_seg;

`ifdef BCD_7SEG_DEBOUNCE_EN
  localparam int DBC = 4;
`else
  localparam int DBC = 0;
`endif
  localparam int LAT = 3 + DBC;
  localparam int PW  = 5 + DBC;

  logic       clk;
  logic       rst;
  logic       button;
  logic       enable;
  logic       seg7all_on;
  logic [6:0] sg7;

  typedef struct {
    string      name;
    logic [6:0] val;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] seg_tab [0:9];

  test_bcd_to_7_seg #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .enable     (enable),
    .seg7all_on (seg7all_on),
    .sg7        (sg7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compare every queued expectation on the falling edge of its due cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.due != cyc || sg7 !== e.val) begin
        n_fail++;
        $display("FAIL %s: sg7=%b required %b (cycle %0d, due %0d)", e.name, sg7, e.val, cyc, e.due);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_in(input string name, input logic [6:0] val, input int d);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.due  = cyc + d;
    q.push_back(e);
  endtask

  // Press and release, checking the display holds until exactly LAT+1 edges after the drive point
  task automatic press(input string name, input logic [6:0] before_v, input logic [6:0] after_v,
                       input int low, input int high);
    button = 1'b0;
    expect_in({name, "_hold"}, before_v, LAT);
    expect_in(name, after_v, LAT + 1);
    tick(low);
    button = 1'b1;
    tick(high);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000;
    seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001;
    seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010;
    seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    rst        = 1'b1;
    button     = 1'b1;
    enable     = 1'b1;
    seg7all_on = 1'b0;

    expect_in("reset_c1", 7'b1111111, 1);
    expect_in("reset_c2", 7'b1111111, 2);
    tick(2);
    rst = 1'b0;
    expect_in("after_reset", 7'b1000000, 1);
    tick(2);

    enable = 1'b0;
    seg7all_on = 1'b1;
    expect_in("blank_over_lamp", 7'b1111111, 1);
    tick(2);
    enable = 1'b1;
    expect_in("lamp_test", 7'b0000000, 1);
    tick(2);
    seg7all_on = 1'b0;
    expect_in("lamp_off", 7'b1000000, 1);
    tick(2);

    for (int i = 1; i <= 10; i++)
      press($sformatf("count_%0d", i), seg_tab[(i - 1) % 10], seg_tab[i % 10], PW, PW);

    enable = 1'b0;
    expect_in("disabled_blank", 7'b1111111, 1);
    tick(2);
    press("disabled_press", 7'b1111111, 7'b1111111, PW, PW);
    enable = 1'b1;
    expect_in("disabled_no_count", 7'b1000000, 1);
    tick(2);

    seg7all_on = 1'b1;
    expect_in("lamp_press_on", 7'b0000000, 1);
    tick(2);
    press("lamp_press", 7'b0000000, 7'b0000000, PW, PW);
    seg7all_on = 1'b0;
    expect_in("lamp_press_counted", 7'b1111001, 1);
    tick(2);

    button = 1'b0;
    expect_in("hold_pre", 7'b1111001, LAT);
    expect_in("hold_inc", 7'b0100100, LAT + 1);
    tick(20);
    expect_in("hold_still", 7'b0100100, 1);
    tick(1);
    button = 1'b1;
    tick(PW);
    expect_in("hold_release", 7'b0100100, 1);
    tick(2);

    for (int i = 3; i <= 5; i++)
      press($sformatf("to5_%0d", i), seg_tab[i - 1], seg_tab[i], PW, PW);

    button = 1'b0;
    tick(1);
    rst = 1'b1;
    expect_in("midpress_rst_c1", 7'b1111111, 1);
    expect_in("midpress_rst_c2", 7'b1111111, 2);
    tick(2);
    rst = 1'b0;
    expect_in("midpress_zero", 7'b1000000, 1);
    tick(15 + DBC);
    expect_in("midpress_held_no_count", 7'b1000000, 1);
    tick(1);
    button = 1'b1;
    tick(PW);
    expect_in("midpress_release_no_count", 7'b1000000, 1);
    tick(2);
    press("midpress_repress", 7'b1000000, 7'b1111001, PW, PW);

`ifdef BCD_7SEG_DEBOUNCE_EN
    button = 1'b0;
    tick(3);
    button = 1'b1;
    tick(10);
    expect_in("db_glitch", 7'b1111001, 1);
    tick(2);

    for (int i = 0; i < 6; i++) begin
      button = (i % 2 == 1);
      tick(1);
    end
    button = 1'b0;
    tick(10);
    button = 1'b1;
    tick(PW);
    expect_in("db_bounce_one", 7'b0100100, 1);
    tick(2);

    button = 1'b0;
    tick(20);
    button = 1'b1;
    tick(PW);
    expect_in("db_hold_one", 7'b0110000, 1);
    tick(2);
`endif

    for (int i = 0; i < 50 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
